// File: rtl/operand_fetch.sv
// Two-stage operand fetch: stage 1 drives the register_block read ports, stage 2 buffers masked operands for execute.
// Optional writeback bypass on same-edge writes: define OPERAND_FETCH_WB_BYPASS_EN.
module operand_fetch #(
  parameter int NUM_LANES = 8,
  parameter int NUM_WARPS = 8,
  parameter int NUM_REGS  = 64,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_valid,
  output logic                               issue_ready,
  input  logic [$clog2(NUM_WARPS)-1:0]       issue_warp,
  input  logic [$clog2(NUM_REGS)-1:0]        issue_rs0,
  input  logic [$clog2(NUM_REGS)-1:0]        issue_rs1,
  input  logic [NUM_LANES-1:0]               issue_mask,
  input  logic [TAG_W-1:0]                   issue_tag,
  output logic [NUM_LANES-1:0]               read_en_0,
  output logic [NUM_LANES-1:0]               read_en_1,
  output logic [$clog2(NUM_REGS)-1:0]        raddr_0,
  output logic [$clog2(NUM_REGS)-1:0]        raddr_1,
  output logic [$clog2(NUM_WARPS)-1:0]       warp_selector,
  input  logic [NUM_LANES*DATA_W-1:0]        rdata_0,
  input  logic [NUM_LANES*DATA_W-1:0]        rdata_1,
`ifdef OPERAND_FETCH_WB_BYPASS_EN
  input  logic [NUM_LANES-1:0]               wb_en,
  input  logic [$clog2(NUM_WARPS)-1:0]       wb_warp,
  input  logic [$clog2(NUM_REGS)-1:0]        wb_addr,
  input  logic [NUM_LANES*DATA_W-1:0]        wb_data,
`endif
  output logic                               ex_valid,
  input  logic                               ex_ready,
  output logic [NUM_LANES*DATA_W-1:0]        ex_op0,
  output logic [NUM_LANES*DATA_W-1:0]        ex_op1,
  output logic [NUM_LANES-1:0]               ex_mask,
  output logic [$clog2(NUM_WARPS)-1:0]       ex_warp,
  output logic [TAG_W-1:0]                   ex_tag,
  output logic [15:0]                        stall_cnt
);

  localparam int WW = $clog2(NUM_WARPS);
  localparam int AW = $clog2(NUM_REGS);

  logic                        s1_valid;
  logic [WW-1:0]               s1_warp;
  logic [AW-1:0]               s1_rs0;
  logic [AW-1:0]               s1_rs1;
  logic [NUM_LANES-1:0]        s1_mask;
  logic [TAG_W-1:0]            s1_tag;
  logic                        s2_valid;
  logic                        issue_fire;
  logic                        advance;
  logic [NUM_LANES*DATA_W-1:0] op0_next;
  logic [NUM_LANES*DATA_W-1:0] op1_next;

  assign issue_ready   = !s1_valid || !s2_valid || ex_ready;
  assign issue_fire    = issue_valid && issue_ready;
  assign advance       = s1_valid && (!s2_valid || ex_ready);

  // Addresses come straight from stage 1, so they hold their last value when idle.
  assign read_en_0     = s1_valid ? s1_mask : '0;
  assign read_en_1     = s1_valid ? s1_mask : '0;
  assign raddr_0       = s1_rs0;
  assign raddr_1       = s1_rs1;
  assign warp_selector = s1_warp;
  assign ex_valid      = s2_valid;

  always_comb begin
    op0_next = '0;
    op1_next = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (s1_mask[i]) begin
        op0_next[i*DATA_W +: DATA_W] = rdata_0[i*DATA_W +: DATA_W];
        op1_next[i*DATA_W +: DATA_W] = rdata_1[i*DATA_W +: DATA_W];
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        // A write landing on the capture edge is not yet visible on rdata.
        if (wb_en[i] && wb_warp == s1_warp && wb_addr == s1_rs0)
          op0_next[i*DATA_W +: DATA_W] = wb_data[i*DATA_W +: DATA_W];
        if (wb_en[i] && wb_warp == s1_warp && wb_addr == s1_rs1)
          op1_next[i*DATA_W +: DATA_W] = wb_data[i*DATA_W +: DATA_W];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_warp  <= '0;
      s1_rs0   <= '0;
      s1_rs1   <= '0;
      s1_mask  <= '0;
      s1_tag   <= '0;
    end else if (issue_fire) begin
      s1_valid <= 1'b1;
      s1_warp  <= issue_warp;
      s1_rs0   <= issue_rs0;
      s1_rs1   <= issue_rs1;
      s1_mask  <= issue_mask;
      s1_tag   <= issue_tag;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      ex_op0   <= '0;
      ex_op1   <= '0;
      ex_mask  <= '0;
      ex_warp  <= '0;
      ex_tag   <= '0;
    end else if (advance) begin
      s2_valid <= 1'b1;
      ex_op0   <= op0_next;
      ex_op1   <= op1_next;
      ex_mask  <= s1_mask;
      ex_warp  <= s1_warp;
      ex_tag   <= s1_tag;
    end else if (s2_valid && ex_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (s2_valid && !ex_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed plus randomized bench for operand_fetch against an in-flight queue model.
module tb_operand_fetch;
  localparam int N  = 8;
  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           issue_valid = 1'b0;
  logic           issue_ready;
  logic [2:0]     issue_warp = '0;
  logic [5:0]     issue_rs0 = '0;
  logic [5:0]     issue_rs1 = '0;
  logic [N-1:0]   issue_mask = '0;
  logic [7:0]     issue_tag = '0;
  logic [N-1:0]   read_en_0, read_en_1;
  logic [5:0]     raddr_0, raddr_1;
  logic [2:0]     warp_selector;
  logic [N*DW-1:0] rdata_0, rdata_1;
  logic           ex_valid;
  logic           ex_ready = 1'b1;
  logic [N*DW-1:0] ex_op0, ex_op1;
  logic [N-1:0]   ex_mask;
  logic [2:0]     ex_warp;
  logic [7:0]     ex_tag;
  logic [15:0]    stall_cnt;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
  logic [N-1:0]   wb_en = '0;
  logic [2:0]     wb_warp = '0;
  logic [5:0]     wb_addr = '0;
  logic [N*DW-1:0] wb_data = '0;
`endif

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_warp(issue_warp),
    .issue_rs0(issue_rs0), .issue_rs1(issue_rs1), .issue_mask(issue_mask), .issue_tag(issue_tag),
    .read_en_0(read_en_0), .read_en_1(read_en_1), .raddr_0(raddr_0), .raddr_1(raddr_1),
    .warp_selector(warp_selector), .rdata_0(rdata_0), .rdata_1(rdata_1),
`ifdef OPERAND_FETCH_WB_BYPASS_EN
    .wb_en(wb_en), .wb_warp(wb_warp), .wb_addr(wb_addr), .wb_data(wb_data),
`endif
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op0(ex_op0), .ex_op1(ex_op1),
    .ex_mask(ex_mask), .ex_warp(ex_warp), .ex_tag(ex_tag), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Register file contents seen by the combinational register_block read.
  logic [DW-1:0] regfile [8][64][N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rdata_0[i*DW +: DW] = regfile[warp_selector][raddr_0][i];
      rdata_1[i*DW +: DW] = regfile[warp_selector][raddr_1][i];
    end
  end

  typedef struct {
    logic [2:0]    warp;
    logic [5:0]    rs0, rs1;
    logic [N-1:0]  mask;
    logic [7:0]    tag;
    logic [N*DW-1:0] op0, op1;
    int            born;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  int    stall = 0;
  int    deliv = 0;
  int    checks = 0;
  int    errors = 0;
  logic  last_fire;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] mkop(input logic [2:0] w, input logic [5:0] r, input logic [N-1:0] m);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (m[i]) v[i*DW +: DW] = regfile[w][r][i];
    return v;
  endfunction

  // Model: an instruction issued at edge k is at the output from edge k+1 until accepted;
  // at most two are in flight, and a third is refused only while the output is held.
  task automatic cycle();
    item_t h, t;
    logic  exp_vld, exp_rdy, s1_has, ex_fire;
    @(negedge clk);
    exp_vld = q.size() > 0 && q[0].born < cyc;
    exp_rdy = (q.size() < 2) || ex_ready;
    chk("ex_valid", ex_valid, exp_vld);
    chk("issue_ready", issue_ready, exp_rdy);
    chk("stall_cnt", stall_cnt, stall[15:0]);
    if (exp_vld) begin
      h = q[0];
      chk("ex_payload", {ex_op0, ex_op1, ex_mask, ex_warp, ex_tag},
          {h.op0, h.op1, h.mask, h.warp, h.tag});
    end
    s1_has = (q.size() == 2) || (q.size() == 1 && q[0].born == cyc);
    if (s1_has) begin
      t = q[q.size()-1];
      chk("read_port", {read_en_0, read_en_1, raddr_0, raddr_1, warp_selector},
          {t.mask, t.mask, t.rs0, t.rs1, t.warp});
    end else begin
      chk("read_en_idle", {read_en_0, read_en_1}, 16'h0);
    end
    last_fire = issue_valid && exp_rdy;
    ex_fire   = exp_vld && ex_ready;
    if (ex_valid && ex_ready) deliv++;
    if (exp_vld && !ex_ready && stall < 65535) stall++;
    @(posedge clk);
    cyc++;
    if (ex_fire) void'(q.pop_front());
    if (last_fire) begin
      t.warp = issue_warp; t.rs0 = issue_rs0; t.rs1 = issue_rs1;
      t.mask = issue_mask; t.tag = issue_tag; t.born = cyc;
      t.op0 = mkop(issue_warp, issue_rs0, issue_mask);
      t.op1 = mkop(issue_warp, issue_rs1, issue_mask);
      q.push_back(t);
    end
    #1;
  endtask

  task automatic set_issue(input logic [2:0] w, input logic [5:0] r0, input logic [5:0] r1,
                           input logic [N-1:0] m, input logic [7:0] tg);
    issue_warp = w; issue_rs0 = r0; issue_rs1 = r1; issue_mask = m; issue_tag = tg;
  endtask

  initial begin
    logic [N*DW-1:0] ea, eb;
    int n;
    for (int w = 0; w < 8; w++)
      for (int r = 0; r < 64; r++)
        for (int l = 0; l < N; l++)
          regfile[w][r][l] = $urandom;
    for (int l = 0; l < N; l++) begin
      regfile[3][5][l]  = 32'hA000_0000 + l;
      regfile[3][42][l] = 32'hB000_0000 + l;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {ex_valid, read_en_0, read_en_1, raddr_0, raddr_1, warp_selector,
        ex_op0, ex_op1, ex_mask, ex_warp, ex_tag, stall_cnt}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single issue
    for (int l = 0; l < N; l++) begin
      ea[l*DW +: DW] = 32'hA000_0000 + l;
      eb[l*DW +: DW] = 32'hB000_0000 + l;
    end
    set_issue(3'd3, 6'h05, 6'h2A, 8'hFF, 8'h11);
    issue_valid = 1'b1;
    cycle();
    issue_valid = 1'b0;
    chk("single_read", {read_en_0, read_en_1, raddr_0, raddr_1, warp_selector},
        {8'hFF, 8'hFF, 6'd5, 6'd42, 3'd3});
    cycle();
    chk("single_out", {ex_valid, ex_op0, ex_op1, ex_tag}, {1'b1, ea, eb, 8'h11});

    // Partial mask: lanes 0, 2, 5, 7 inactive
    set_issue(3'd3, 6'h05, 6'h2A, 8'h5A, 8'h22);
    issue_valid = 1'b1;
    cycle();
    issue_valid = 1'b0;
    chk("partial_read_en", {read_en_0, read_en_1}, {8'h5A, 8'h5A});
    cycle();
    for (int l = 0; l < N; l++)
      if (l == 0 || l == 2 || l == 5 || l == 7) begin
        ea[l*DW +: DW] = '0;
        eb[l*DW +: DW] = '0;
      end
    chk("partial_out", {ex_valid, ex_op0, ex_op1, ex_mask}, {1'b1, ea, eb, 8'h5A});
    cycle();

    // Full throughput
    deliv = 0;
    for (int k = 0; k < 64; k++) begin
      set_issue(3'(k % 8), 6'(k), 6'($urandom_range(0, 63)), 8'($urandom), 8'(k));
      issue_valid = 1'b1;
      cycle();
    end
    issue_valid = 1'b0;
    repeat (2) cycle();
    chk("thru_delivered", deliv, 64);
    chk("thru_stall", stall_cnt, 16'd0);

    // Backpressure: output held for four stalled cycles
    deliv = 0;
    ex_ready = 1'b0;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      set_issue(3'($urandom), 6'($urandom), 6'($urandom), 8'($urandom), 8'(8'h40 + k));
      issue_valid = 1'b1;
      do begin
        if (n >= 6) ex_ready = 1'b1;
        cycle();
        n++;
      end while (!last_fire && n < 50);
      chk("bp_accepted", last_fire, 1'b1);
    end
    issue_valid = 1'b0;
    ex_ready = 1'b1;
    repeat (3) cycle();
    chk("bp_stall", stall_cnt, 16'd4);
    chk("bp_delivered", deliv, 3);
    chk("bp_ready_after", issue_ready, 1'b1);

    // Randomized traffic, including empty masks and rs0 == rs1
    for (int k = 0; k < 400; k++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      ex_ready    = ($urandom_range(0, 9) < 7);
      set_issue(3'($urandom), 6'($urandom), 6'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 7) == 0) issue_mask = '0;
      if ($urandom_range(0, 5) == 0) issue_rs1 = issue_rs0;
      cycle();
    end
    issue_valid = 1'b0;
    ex_ready = 1'b1;
    repeat (3) cycle();

    // Reset with both stages full
    ex_ready = 1'b0;
    issue_valid = 1'b1;
    set_issue(3'd1, 6'd9, 6'd10, 8'hF0, 8'h77);
    repeat (2) cycle();
    issue_valid = 1'b0;
    chk("pre_reset_full", {ex_valid, issue_ready}, 2'b10);
    #2 rst = 1'b1;
    #1;
    chk("midrun_reset", {ex_valid, read_en_0, read_en_1, raddr_0, raddr_1, warp_selector,
        ex_op0, ex_op1, ex_mask, ex_warp, ex_tag, stall_cnt}, '0);
    q.delete();
    stall = 0;
    @(negedge clk);
    rst = 1'b0;
    ex_ready = 1'b1;
    @(posedge clk); #1;
    repeat (4) cycle();

`ifdef OPERAND_FETCH_WB_BYPASS_EN
    for (int l = 0; l < N; l++) wb_data[l*DW +: DW] = 32'hC0DE_0000 + l;
    set_issue(3'd2, 6'd7, 6'd8, 8'hFF, 8'h99);
    issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    wb_en = 8'hFF; wb_warp = 3'd2; wb_addr = 6'd7;
    @(posedge clk); #1;
    chk("bypass_hit", ex_op0, wb_data);
    wb_en = '0;
    issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    wb_en = 8'hFF; wb_warp = 3'd1;
    @(posedge clk); #1;
    chk("bypass_miss", ex_op0, mkop(3'd2, 6'd7, 8'hFF));
    wb_en = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Two-stage operand fetch pipeline between the warp issue logic and execute.
- Accepts one issued instruction per cycle: warp id, two source register addresses, active-lane mask.
- Drives both read ports and the warp_selector of register_block, then captures the per-lane operands into an output buffer.
- Presents the operands to execute over a valid/ready handshake.

Parameters:
NUM_LANES, 8, lanes per warp; width of the lane masks and enables
NUM_WARPS, 8, warps; warp id width = clog2(NUM_WARPS) = 3
NUM_REGS, 64, registers per lane; address width = clog2(NUM_REGS) = 6
DATA_W, 32, register width
TAG_W, 8, opaque instruction tag carried alongside the operands

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
issue_valid  in  1  issue request
issue_ready  out  1  block can accept the request this cycle
issue_warp  in  3  warp id
issue_rs0  in  6  source register 0
issue_rs1  in  6  source register 1
issue_mask  in  NUM_LANES  active lanes
issue_tag  in  TAG_W  pass-through tag
read_en_0  out  NUM_LANES  register_block port 0 lane read enables
read_en_1  out  NUM_LANES  register_block port 1 lane read enables
raddr_0  out  6  register_block port 0 address
raddr_1  out  6  register_block port 1 address
warp_selector  out  3  register_block warp select
rdata_0  in  NUM_LANES*DATA_W  port 0 data; lane i at [i*DATA_W +: DATA_W]
rdata_1  in  NUM_LANES*DATA_W  port 1 data; same packing
ex_valid  out  1  operands valid
ex_ready  in  1  execute accepts
ex_op0  out  NUM_LANES*DATA_W  operand 0, all lanes
ex_op1  out  NUM_LANES*DATA_W  operand 1, all lanes
ex_mask  out  NUM_LANES  lane mask
ex_warp  out  3  warp id
ex_tag  out  TAG_W  tag
stall_cnt  out  16  cycles in which the output was held

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0. Every output and internal register = 0.
- Stage 1 (read): registers warp, rs0, rs1, mask and tag on an issue handshake (issue_valid && issue_ready at posedge).
  - While s1_valid: read_en_0 = read_en_1 = s1_mask; raddr_0 = s1_rs0; raddr_1 = s1_rs1; warp_selector = s1_warp.
  - While !s1_valid: read_en_* = 0. raddr_*, warp_selector hold their last values (no toggling).
- Register_block read is combinational. rdata is sampled in the same cycle s1 drives the addresses.
- Stage 2 (output buffer): advance = s1_valid && (!s2_valid || ex_ready).
  - On advance: ex_op0/ex_op1 lane i = rdata lane i if s1_mask[i], else 0. ex_mask/ex_warp/ex_tag copied from stage 1. s2_valid=1.
  - If s2_valid && ex_ready && !advance: s2_valid=0.
- issue_ready = !s1_valid || !s2_valid || ex_ready (combinational).
- Stage 1 update on a clock edge:
  - Issue handshake: load the new request, s1_valid=1.
  - Else if advance: s1_valid=0.
  - Simultaneous advance + issue handshake: stage 1 loads the new request while stage 2 takes the old one.
- Latency: issue handshake at edge N → ex_valid at edge N+1 (visible after N+1). Full throughput is 1 instruction/cycle with ex_ready held high.
- Output stability: ex_* are stable while ex_valid && !ex_ready. No data is dropped or duplicated under backpressure.
- issue_mask = 0:
  - The instruction still flows through the pipeline.
  - read_en_* = 0 while it is in stage 1.
  - Its ex_op0 and ex_op1 are all zero.
- rs0 == rs1: both ports read the same register. Both operands are equal.
- stall_cnt increments on each cycle with s2_valid && !ex_ready. Saturates at 16'hFFFF. Cleared only by rst.
- Reset mid-operation: any in-flight instruction is discarded. No ex_valid appears afterwards for it.

Optional Feature:
Macro OPERAND_FETCH_WB_BYPASS_EN.
- Defined: extra inputs wb_en[NUM_LANES], wb_warp[3], wb_addr[6] and wb_data[NUM_LANES*DATA_W] carry the writeback bus into register_block.
  - In the cycle stage 1 samples: if wb_en[i] && wb_warp == s1_warp && wb_addr == s1_rsX, lane i of operand X takes wb_data lane i instead of rdata.
  - This covers the write landing at the same edge the operand is captured.
  - The lane mask still zeroes inactive lanes.
- Undefined: the ports are absent. Operands come only from rdata.

Test Plan:
- Reset: assert rst mid-run with s1 and s2 full → all outputs 0 immediately; ex_valid stays 0 until a new issue.
- Single issue (warp 3, rs0=6'h05, rs1=6'h2A, mask=8'hFF, tag=8'h11); register_block preloaded with lane i r5=32'hA000_0000+i and r42=32'hB000_0000+i.
  - Expect read_en_0/1=8'hFF, raddr_0=5, raddr_1=42, warp_selector=3.
  - Next cycle: ex_valid=1 with op0 lane i=A000_000i, op1 lane i=B000_000i, tag=8'h11.
- Partial mask: issue mask=8'h5A → read_en_* =8'h5A; ex_op lanes 0, 2, 5 and 7 = 0.
- Backpressure: 3 back-to-back issues, ex_ready=0 for 4 cycles.
  - issue_ready drops after 2 accepted; ex_* are held; stall_cnt=4.
  - After ex_ready=1: all 3 delivered in order, then issue_ready=1.
- Full throughput: 64 issues, ex_ready=1, rs0 sweeping 0..63 across warps 0..7 → one ex_valid per cycle, operands correct, stall_cnt=0.
- Bypass (macro defined): wb_en=8'hFF, wb_warp=2, wb_addr=7, wb_data lane i=32'hC0DE_0000+i in the same cycle stage 1 holds warp 2 rs0=7 → ex_op0 lane i=C0DE_000i. With wb_warp=1: ex_op0 = rdata.
